ahb_sram_slave: RTL and testbench

- AHB-Lite responder (slave) for the single-transfer, NONSEQ-only master used by the fetch stage and the data port.
- Holds a word-organised SRAM that backs instruction fetch and data load/store.
- Inserts a configurable number of wait states.
- Returns the two-cycle ERROR response for illegal transfers.

---
 rtl/ahb_sram_slave.sv | 142 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-transfer SRAM responder with programmable wait states and the
// two-cycle ERROR response for misaligned, oversized or out-of-range transfers.
module ahb_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam logic [32:0] ByteSpan = 33'd1 << (ADDR_WIDTH + 2);

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [1:0]            dp_size_q, dp_size_d;
  logic [1:0]            dp_lane_q, dp_lane_d;
  logic [ADDR_WIDTH-1:0] dp_word_q, dp_word_d;
  logic [31:0]           mem [2**ADDR_WIDTH];

  logic [31:0] offset;
  logic        illegal, capture, complete;
  logic [3:0]  be;
  logic        unused_inputs;

  assign unused_inputs = ^{HBURST, HTRANS[0], HMASTLOCK, HPROT};

  assign offset   = HADDR - BASE_ADDR;
  assign illegal  = (HSIZE > 3'b010) ||
                    (HSIZE == 3'b001 && HADDR[0]) ||
                    (HSIZE == 3'b010 && HADDR[1:0] != 2'b00) ||
                    ({1'b0, offset} >= ByteSpan);
  assign capture  = HSEL && HREADY && HTRANS[1] && HREADYOUT;
  // Legal data phase sits in StIdle with dp_valid_q set during its completing cycle.
  assign complete = (state_q == StIdle) && dp_valid_q;

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      StWait:  HREADYOUT = 1'b0;
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      StErr2:  HRESP = 1'b1;
      default: ;
    endcase
    HRDATA = (complete && !dp_write_q) ? mem[dp_word_q] : '0;
  end

  always_comb begin
    unique case (dp_size_q)
      2'b00:   be = 4'b0001 << dp_lane_q;
      2'b01:   be = dp_lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_size_d  = dp_size_q;
    dp_lane_d  = dp_lane_q;
    dp_word_d  = dp_word_q;
    unique case (state_q)
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StIdle;
      end
      StErr1: state_d = StErr2;
      default: begin
        state_d    = StIdle;
        dp_valid_d = 1'b0;
        if (capture) begin
          if (illegal) begin
            state_d = StErr1;
          end else begin
            dp_valid_d = 1'b1;
            dp_write_d = HWRITE;
            dp_size_d  = HSIZE[1:0];
            dp_lane_d  = HADDR[1:0];
            dp_word_d  = offset[ADDR_WIDTH+1:2];
            if (WAIT_STATES > 0) begin
              state_d = StWait;
              cnt_d   = 4'(WAIT_STATES);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_size_q  <= '0;
      dp_lane_q  <= '0;
      dp_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_size_q  <= dp_size_d;
      dp_lane_q  <= dp_lane_d;
      dp_word_q  <= dp_word_d;
    end
  end

  // Storage is deliberately outside reset; contents survive RES.
  always_ff @(posedge CLK) begin
    if (complete && dp_write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[dp_word_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 2 wait states) driven by a pipelined
// single-transfer master, checked against a word-array memory model.
module tb_ahb_sram_slave;

  localparam int unsigned AW    = 8;
  localparam int unsigned Words = 1 << AW;
  localparam logic [31:0] Span  = 32'(4 * Words);
  localparam logic [31:0] Base  = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [2:0]  HBURST = '0;
  logic [1:0]  HTRANS = '0;
  logic        HMASTLOCK = 1'b0;
  logic [3:0]  HPROT = '0;
  logic [31:0] HWDATA = '0;
  logic        sel2 = 1'b0;

  logic [31:0] rdata0, rdata2, dut_rdata;
  logic        rdy0, rdy2, resp0, resp2, dut_rdy, dut_resp;

  assign dut_rdy   = sel2 ? rdy2 : rdy0;
  assign dut_resp  = sel2 ? resp2 : resp0;
  assign dut_rdata = sel2 ? rdata2 : rdata0;

  always #5 CLK = ~CLK;

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0), .BASE_ADDR(Base)) u_dut0 (
    .CLK(CLK), .RES(RES), .HSEL(HSEL & ~sel2), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HWDATA(HWDATA), .HREADY(rdy0), .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(2), .BASE_ADDR(Base)) u_dut2 (
    .CLK(CLK), .RES(RES), .HSEL(HSEL & sel2), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HWDATA(HWDATA), .HREADY(rdy2), .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [2][Words];
  bit          pend_valid = 0, pend_wr = 0, pend_err = 0;
  logic [31:0] pend_wdata = '0, pend_rdata = '0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (ws=%0d) at %0t: got %h, expected %h", name, sel2 ? 2 : 0, $time,
               act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] off = addr - Base;
    if (size > 3'd2) return 1'b0;
    if (addr % (32'd1 << size) != 0) return 1'b0;
    return off < Span;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] res = old;
    int n  = 1 << size;
    int lo = int'(addr % 4) / n * n;
    for (int i = lo; i < lo + n; i++) res[8*i +: 8] = wdata[8*i +: 8];
    return res;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'(((addr - Base) >> 2) % Words);
  endfunction

  // Called just after a falling edge with the next cycle's inputs driven; finishes any
  // outstanding data phase and checks its latency and response.
  task automatic wait_complete();
    int waits = 0;
    int exp_waits = pend_valid ? (pend_err ? 1 : (sel2 ? 2 : 0)) : 0;
    while (!dut_rdy && waits < 20) begin
      check("wait_hresp", 32'(dut_resp), 32'(pend_valid && pend_err));
      check("wait_hrdata", dut_rdata, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      waits++;
    end
    check("latency", 32'(waits), 32'(exp_waits));
    check("hresp", 32'(dut_resp), 32'(pend_valid && pend_err));
    check("hrdata", dut_rdata, (pend_valid && !pend_err && !pend_wr) ? pend_rdata : 32'h0);
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_rd);
    int d = sel2 ? 1 : 0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    HWDATA = pend_wdata;
    wait_complete();
    @(posedge CLK);
    pend_valid = 1; pend_wr = wr; pend_err = exp_err; pend_wdata = wdata; pend_rdata = exp_rd;
    if (wr && is_legal(addr, size)) model[d][widx(addr)] = merge(model[d][widx(addr)], wdata,
                                                                 addr, size);
    @(negedge CLK);
  endtask

  task automatic model_issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
    int d = sel2 ? 1 : 0;
    bit ok = is_legal(addr, size);
    issue(wr, addr, size, wdata, !ok, (!wr && ok) ? model[d][widx(addr)] : 32'h0);
  endtask

  task automatic idle(input bit hsel, input logic [1:0] trans);
    HSEL = hsel; HTRANS = trans; HWRITE = 1'($urandom); HADDR = $urandom % Span;
    HSIZE = 3'b010;
    HWDATA = pend_valid ? pend_wdata : $urandom;
    wait_complete();
    @(posedge CLK);
    pend_valid = 0;
    @(negedge CLK);
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1, 32'h10,  3'd2, 32'hDEAD_BEEF, 0, 32'h0};
    tbl[1]  = '{0, 32'h10,  3'd2, 32'h0,         0, 32'hDEAD_BEEF};
    tbl[2]  = '{1, 32'h20,  3'd2, 32'h1122_3344, 0, 32'h0};
    tbl[3]  = '{1, 32'h21,  3'd0, 32'h0000_AA00, 0, 32'h0};
    tbl[4]  = '{1, 32'h22,  3'd1, 32'h5566_0000, 0, 32'h0};
    tbl[5]  = '{0, 32'h20,  3'd2, 32'h0,         0, 32'h5566_AA44};
    tbl[6]  = '{1, 32'h00,  3'd2, 32'h0BAD_F00D, 0, 32'h0};
    tbl[7]  = '{1, 32'h40,  3'd2, 32'hCAFE_F00D, 0, 32'h0};
    tbl[8]  = '{0, 32'h02,  3'd2, 32'h0,         1, 32'h0};
    tbl[9]  = '{1, 32'h440, 3'd2, 32'h1234_5678, 1, 32'h0};
    tbl[10] = '{0, 32'h00,  3'd2, 32'h0,         0, 32'h0BAD_F00D};
    tbl[11] = '{0, 32'h40,  3'd2, 32'h0,         0, 32'hCAFE_F00D};
    tbl[12] = '{0, 32'h21,  3'd0, 32'h0,         0, 32'h5566_AA44};
    tbl[13] = '{1, 32'h23,  3'd1, 32'hFFFF_FFFF, 1, 32'h0};
    tbl[14] = '{0, 32'h20,  3'd3, 32'h0,         1, 32'h0};
    tbl[15] = '{1, 32'h3FC, 3'd2, 32'hFEED_FACE, 0, 32'h0};
    tbl[16] = '{0, 32'h3FC, 3'd2, 32'h0,         0, 32'hFEED_FACE};
    tbl[17] = '{1, 32'h400, 3'd0, 32'h0000_00EE, 1, 32'h0};
    tbl[18] = '{0, 32'h20,  3'd2, 32'h0,         0, 32'h5566_AA44};

    #1;
    check("reset_ready0", 32'(rdy0), 32'h1);
    check("reset_resp0", 32'(resp0), 32'h0);
    check("reset_rdata0", rdata0, 32'h0);
    check("reset_ready2", 32'(rdy2), 32'h1);
    check("reset_resp2", 32'(resp2), 32'h0);
    check("reset_rdata2", rdata2, 32'h0);
    repeat (3) @(negedge CLK);
    RES = 1'b1;

    // Preload every word so later reads have defined contents.
    for (int d = 0; d < 2; d++) begin
      sel2 = 1'(d);
      for (int w = 0; w < int'(Words); w++) model_issue(1'b1, 32'(w * 4), 3'd2, $urandom);
      idle(1'b0, 2'b00);
    end

    for (int d = 0; d < 2; d++) begin
      sel2 = 1'(d);
      for (int i = 0; i < 19; i++)
        issue(tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata, tbl[i].err, tbl[i].rdata);
      idle(1'b0, 2'b00);

      // IDLE/BUSY while selected and NONSEQ while deselected are not transfers.
      idle(1'b1, 2'b00);
      idle(1'b1, 2'b01);
      idle(1'b0, 2'b10);
      idle(1'b0, 2'b11);
      issue(1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF);
      issue(1'b0, 32'h20, 3'd2, 32'h0, 1'b0, 32'h5566_AA44);
      idle(1'b0, 2'b00);
    end

    // Reset during the second wait cycle of a write must discard it.
    begin
      logic [31:0] old;
      sel2 = 1'b1;
      old  = model[1][widx(32'h30)];
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h30; HWRITE = 1'b1; HSIZE = 3'd2;
      @(posedge CLK);
      @(negedge CLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = ~old;
      check("rst_wait1_ready", 32'(dut_rdy), 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      check("rst_wait2_ready", 32'(dut_rdy), 32'h0);
      #2 RES = 1'b0;
      #1;
      check("rst_async_ready", 32'(dut_rdy), 32'h1);
      check("rst_async_resp", 32'(dut_resp), 32'h0);
      check("rst_async_rdata", dut_rdata, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      RES = 1'b1;
      pend_valid = 0;
      pend_wdata = '0;
      issue(1'b0, 32'h30, 3'd2, 32'h0, 1'b0, old);
      idle(1'b0, 2'b00);
    end

    for (int d = 0; d < 2; d++) begin
      sel2 = 1'(d);
      repeat (150) begin
        logic [2:0]  size;
        logic [31:0] addr;
        HPROT = 4'($urandom); HBURST = 3'($urandom); HMASTLOCK = 1'($urandom);
        if ($urandom_range(0, 3) == 0) idle(1'($urandom), 2'($urandom_range(0, 1)));
        size = ($urandom_range(0, 7) == 7) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, Span - 1));
        if (size <= 3'd2 && $urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << size) - 1);
        model_issue(1'($urandom), addr, size, $urandom);
      end
      idle(1'b0, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
